// File: rtl/dram_controller_banked.sv
// rtl/dram_controller_banked.sv - banked 68000 DRAM controller with CAS-before-RAS refresh
//
// Ports:
//   CLK, RST            clock (rising edge) and asynchronous active-low reset
//   AS, UDS, LDS, RW    68000 bus strobes, active low; RW=1 is a read
//   CS                  DRAM select from address decode, active high
//   ADDR_IN             CPU address
//   ADDR_OUT            multiplexed row/column address to the array
//   RAS                 per-bank row strobes, active low
//   CAS_LOWER/CAS_UPPER byte-lane column strobes, active low
//   WE, OE              array write / output enable, active low
//   DTACK_DRAM          data acknowledge to the DTACK combiner, active low
module dram_controller_banked #(
  parameter int ADDR_BITS      = 24,
  parameter int MUX_BITS       = 11,
  parameter int BANKS          = 2,
  parameter int REFRESH_CYCLES = 124,
  parameter int RAS_PRECHARGE  = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 AS,
  input  logic                 UDS,
  input  logic                 LDS,
  input  logic                 RW,
  input  logic                 CS,
  input  logic [ADDR_BITS-1:0] ADDR_IN,
  output logic [MUX_BITS-1:0]  ADDR_OUT,
  output logic [BANKS-1:0]     RAS,
  output logic                 CAS_LOWER,
  output logic                 CAS_UPPER,
  output logic                 WE,
  output logic                 OE,
  output logic                 DTACK_DRAM
);

  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int CNT_W  = $clog2(REFRESH_CYCLES);
  localparam int PRE_W  = (RAS_PRECHARGE > 1) ? $clog2(RAS_PRECHARGE) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LOAD   = PRE_W'(RAS_PRECHARGE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_COL, S_ACK, S_PRE, S_REF_CAS, S_REF_RAS, S_REF_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [BANKS-1:0]   ras_q, ras_d;
  logic               cas_u_q, cas_u_d;
  logic               cas_l_q, cas_l_d;
  logic               we_q, we_d;
  logic               oe_q, oe_d;
  logic               dtack_q, dtack_d;
  logic               rw_q, rw_d;
  logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]   ref_cnt_q, ref_cnt_d;
  logic               ref_pend_q, ref_pend_d;

  logic [BANK_W-1:0]  bank;
  logic [BANKS-1:0]   ras_sel;
  logic               start;
  logic               ref_expire;
  logic               ref_take;
  logic               release_all;
  logic               unused_addr;

  // Bit 0 and any bits above the bank field never reach the array.
  assign unused_addr = ^ADDR_IN;

  if (BANKS > 1) begin : g_bank
    assign bank = ADDR_IN[2*MUX_BITS+1 +: BANK_W];
  end else begin : g_one_bank
    assign bank = '0;
  end

  always_comb begin
    ras_sel       = '1;
    ras_sel[bank] = 1'b0;
  end

  assign start      = !AS && CS && (!UDS || !LDS);
  // An expiry on this very edge counts as pending, so an idle controller
  // starts refresh on the edge the counter runs out.
  assign ref_expire = (ref_cnt_q == '0);
  assign ref_take   = (state_q == S_IDLE) && (ref_pend_q || ref_expire);

  always_comb begin
    if (state_q == S_COL || state_q == S_ACK) ADDR_OUT = ADDR_IN[MUX_BITS:1];
    else                                     ADDR_OUT = ADDR_IN[2*MUX_BITS:MUX_BITS+1];
  end

  always_comb begin
    state_d     = state_q;
    ras_d       = ras_q;
    cas_u_d     = cas_u_q;
    cas_l_d     = cas_l_q;
    we_d        = we_q;
    oe_d        = oe_q;
    dtack_d     = dtack_q;
    rw_d        = rw_q;
    pre_cnt_d   = pre_cnt_q;
    release_all = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ref_take) begin
          state_d = S_REF_CAS;
          cas_u_d = 1'b0;
          cas_l_d = 1'b0;
          we_d    = 1'b1;
          oe_d    = 1'b1;
        end else if (start) begin
          state_d = S_ROW;
          ras_d   = ras_sel;
          we_d    = RW;
          rw_d    = RW;
        end
      end
      S_ROW: begin
        if (AS) release_all = 1'b1;
        else    state_d = S_COL;
      end
      S_COL: begin
        if (AS) begin
          release_all = 1'b1;
        end else begin
          state_d = S_ACK;
          cas_u_d = UDS;
          cas_l_d = LDS;
          oe_d    = !rw_q;
          dtack_d = 1'b0;
        end
      end
      S_ACK: begin
        if (AS) begin
          release_all = 1'b1;
        end else begin
          // Write data strobes may arrive late; track them each cycle.
          cas_u_d = UDS;
          cas_l_d = LDS;
        end
      end
      S_PRE: begin
        if (pre_cnt_q == '0) state_d = S_IDLE;
        else                 pre_cnt_d = pre_cnt_q - 1'b1;
      end
      S_REF_CAS: begin
        state_d = S_REF_RAS;
        ras_d   = '0;
      end
      S_REF_RAS:  state_d = S_REF_HOLD;
      S_REF_HOLD: release_all = 1'b1;
      default:    state_d = S_IDLE;
    endcase

    if (release_all) begin
      state_d   = S_PRE;
      ras_d     = '1;
      cas_u_d   = 1'b1;
      cas_l_d   = 1'b1;
      we_d      = 1'b1;
      oe_d      = 1'b1;
      dtack_d   = 1'b1;
      pre_cnt_d = PRE_LOAD;
    end

    ref_cnt_d = ref_expire ? CNT_RELOAD : ref_cnt_q - 1'b1;
    // A second expiry while one is still pending is simply absorbed.
    if (ref_take)        ref_pend_d = 1'b0;
    else if (ref_expire) ref_pend_d = 1'b1;
    else                 ref_pend_d = ref_pend_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      ras_q      <= '1;
      cas_u_q    <= 1'b1;
      cas_l_q    <= 1'b1;
      we_q       <= 1'b1;
      oe_q       <= 1'b1;
      dtack_q    <= 1'b1;
      rw_q       <= 1'b1;
      pre_cnt_q  <= '0;
      ref_cnt_q  <= CNT_RELOAD;
      ref_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ras_q      <= ras_d;
      cas_u_q    <= cas_u_d;
      cas_l_q    <= cas_l_d;
      we_q       <= we_d;
      oe_q       <= oe_d;
      dtack_q    <= dtack_d;
      rw_q       <= rw_d;
      pre_cnt_q  <= pre_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
    end
  end

  assign RAS        = ras_q;
  assign CAS_UPPER  = cas_u_q;
  assign CAS_LOWER  = cas_l_q;
  assign WE         = we_q;
  assign OE         = oe_q;
  assign DTACK_DRAM = dtack_q;

endmodule

// File: tb/tb_dram_controller_banked.sv
// tb/tb_dram_controller_banked.sv - directed bench for dram_controller_banked
module tb_dram_controller_banked;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        AS = 1'b1, UDS = 1'b1, LDS = 1'b1, RW = 1'b1, CS = 1'b0;
  logic [23:0] ADDR_IN = '0;
  logic [10:0] ADDR_OUT;
  logic [1:0]  RAS;
  logic        CAS_LOWER, CAS_UPPER, WE, OE, DTACK_DRAM;

  // {RAS[1:0], CAS_UPPER, CAS_LOWER, WE, OE, DTACK_DRAM}
  logic [6:0]  strobes;
  assign strobes = {RAS, CAS_UPPER, CAS_LOWER, WE, OE, DTACK_DRAM};

  localparam logic [6:0] ST_IDLE   = 7'b11_11111;
  localparam logic [6:0] ST_RD_ROW = 7'b10_11111;
  localparam logic [6:0] ST_RD_ACK = 7'b10_00100;
  localparam logic [6:0] ST_WR_ROW = 7'b01_11011;
  localparam logic [6:0] ST_WR_ACK = 7'b01_10010;
  localparam logic [6:0] ST_RF_CAS = 7'b11_00111;
  localparam logic [6:0] ST_RF_RAS = 7'b00_00111;

  int n_cmp = 0;
  int n_bad = 0;

  dram_controller_banked dut (
    .CLK(CLK), .RST(RST), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .CS(CS),
    .ADDR_IN(ADDR_IN), .ADDR_OUT(ADDR_OUT), .RAS(RAS),
    .CAS_LOWER(CAS_LOWER), .CAS_UPPER(CAS_UPPER), .WE(WE), .OE(OE),
    .DTACK_DRAM(DTACK_DRAM)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1; CS = 1'b0;
  endtask

  // Leaves the bench at a falling edge just after reset release; the next
  // rising edge is edge 1.
  task automatic do_reset();
    bus_idle();
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic start_cycle(input logic [23:0] a, input logic rw,
                             input logic u, input logic l, input logic cs);
    ADDR_IN = a; RW = rw; UDS = u; LDS = l; CS = cs; AS = 1'b0;
  endtask

  task automatic test_reset();
    bus_idle();
    @(negedge CLK);
    RST = 1'b0;
    #1;
    n_cmp++; if (strobes !== ST_IDLE) begin n_bad++; $display("FAIL reset_hold strobes=%b exp=%b", strobes, ST_IDLE); end
    @(negedge CLK);
    RST = 1'b1;
    edges(1);
    n_cmp++; if (strobes !== ST_IDLE) begin n_bad++; $display("FAIL reset_release strobes=%b exp=%b", strobes, ST_IDLE); end
  endtask

  task automatic test_read();
    do_reset();
    start_cycle(24'h120034, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    n_cmp++; if (ADDR_OUT !== 11'h120) begin n_bad++; $display("FAIL rd_addr_idle addr=%h exp=120", ADDR_OUT); end
    edges(1);
    n_cmp++; if (strobes !== ST_RD_ROW) begin n_bad++; $display("FAIL rd_e0 strobes=%b exp=%b", strobes, ST_RD_ROW); end
    n_cmp++; if (ADDR_OUT !== 11'h120) begin n_bad++; $display("FAIL rd_row_addr addr=%h exp=120", ADDR_OUT); end
    edges(1);
    n_cmp++; if (ADDR_OUT !== 11'h01A) begin n_bad++; $display("FAIL rd_col_addr addr=%h exp=01a", ADDR_OUT); end
    n_cmp++; if (strobes !== ST_RD_ROW) begin n_bad++; $display("FAIL rd_e1 strobes=%b exp=%b", strobes, ST_RD_ROW); end
    edges(1);
    n_cmp++; if (strobes !== ST_RD_ACK) begin n_bad++; $display("FAIL rd_e2 strobes=%b exp=%b", strobes, ST_RD_ACK); end
    n_cmp++; if (ADDR_OUT !== 11'h01A) begin n_bad++; $display("FAIL rd_ack_addr addr=%h exp=01a", ADDR_OUT); end
    edges(1);
    n_cmp++; if (strobes !== ST_RD_ACK) begin n_bad++; $display("FAIL rd_hold strobes=%b exp=%b", strobes, ST_RD_ACK); end
    AS = 1'b1; UDS = 1'b1; LDS = 1'b1;
    edges(1);
    n_cmp++; if (strobes !== ST_IDLE) begin n_bad++; $display("FAIL rd_release strobes=%b exp=%b", strobes, ST_IDLE); end
    n_cmp++; if (ADDR_OUT !== 11'h120) begin n_bad++; $display("FAIL rd_release_addr addr=%h exp=120", ADDR_OUT); end
  endtask

  task automatic test_write();
    do_reset();
    start_cycle(24'h800035, 1'b0, 1'b1, 1'b0, 1'b1);
    edges(1);
    n_cmp++; if (strobes !== ST_WR_ROW) begin n_bad++; $display("FAIL wr_e0 strobes=%b exp=%b", strobes, ST_WR_ROW); end
    n_cmp++; if (ADDR_OUT !== 11'h000) begin n_bad++; $display("FAIL wr_row_addr addr=%h exp=000", ADDR_OUT); end
    edges(1);
    n_cmp++; if (ADDR_OUT !== 11'h01A) begin n_bad++; $display("FAIL wr_col_addr addr=%h exp=01a", ADDR_OUT); end
    edges(1);
    n_cmp++; if (strobes !== ST_WR_ACK) begin n_bad++; $display("FAIL wr_e2 strobes=%b exp=%b", strobes, ST_WR_ACK); end
    // Late upper strobe during ACK is followed by CAS_UPPER.
    UDS = 1'b0;
    edges(1);
    n_cmp++; if (strobes !== 7'b01_00010) begin n_bad++; $display("FAIL wr_late_uds strobes=%b exp=0100010", strobes); end
    AS = 1'b1; UDS = 1'b1; LDS = 1'b1;
    edges(1);
    n_cmp++; if (strobes !== ST_IDLE) begin n_bad++; $display("FAIL wr_release strobes=%b exp=%b", strobes, ST_IDLE); end
    do_reset();
    start_cycle(24'h800035, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      edges(1);
      n_cmp++; if (strobes !== ST_IDLE) begin n_bad++; $display("FAIL wr_cs0 cyc=%0d strobes=%b exp=%b", i, strobes, ST_IDLE); end
    end
    bus_idle();
  endtask

  task automatic test_refresh();
    do_reset();
    for (int i = 1; i <= 123; i++) begin
      edges(1);
      n_cmp++; if (strobes !== ST_IDLE) begin n_bad++; $display("FAIL ref_early edge=%0d strobes=%b exp=%b", i, strobes, ST_IDLE); end
    end
    edges(1);
    n_cmp++; if (strobes !== ST_RF_CAS) begin n_bad++; $display("FAIL ref_cas strobes=%b exp=%b", strobes, ST_RF_CAS); end
    edges(1);
    n_cmp++; if (strobes !== ST_RF_RAS) begin n_bad++; $display("FAIL ref_ras strobes=%b exp=%b", strobes, ST_RF_RAS); end
    edges(1);
    n_cmp++; if (strobes !== ST_RF_RAS) begin n_bad++; $display("FAIL ref_hold strobes=%b exp=%b", strobes, ST_RF_RAS); end
    edges(1);
    n_cmp++; if (strobes !== ST_IDLE) begin n_bad++; $display("FAIL ref_release strobes=%b exp=%b", strobes, ST_IDLE); end
    edges(120);
    n_cmp++; if (strobes !== ST_IDLE) begin n_bad++; $display("FAIL ref2_early strobes=%b exp=%b", strobes, ST_IDLE); end
    edges(1);
    n_cmp++; if (strobes !== ST_RF_CAS) begin n_bad++; $display("FAIL ref2_cas strobes=%b exp=%b", strobes, ST_RF_CAS); end
  endtask

  task automatic test_refresh_collision();
    do_reset();
    edges(123);
    start_cycle(24'h120034, 1'b1, 1'b0, 1'b0, 1'b1);
    edges(1);
    n_cmp++; if (strobes !== ST_RF_CAS) begin n_bad++; $display("FAIL col_ref_first strobes=%b exp=%b", strobes, ST_RF_CAS); end
    edges(1);
    n_cmp++; if (strobes !== ST_RF_RAS) begin n_bad++; $display("FAIL col_ref_ras strobes=%b exp=%b", strobes, ST_RF_RAS); end
    edges(2);
    n_cmp++; if (strobes !== ST_IDLE) begin n_bad++; $display("FAIL col_ref_release strobes=%b exp=%b", strobes, ST_IDLE); end
    edges(2);
    n_cmp++; if (strobes !== ST_IDLE) begin n_bad++; $display("FAIL col_pre_wait strobes=%b exp=%b", strobes, ST_IDLE); end
    edges(1);
    n_cmp++; if (strobes !== ST_RD_ROW) begin n_bad++; $display("FAIL col_cpu_row strobes=%b exp=%b", strobes, ST_RD_ROW); end
    edges(2);
    n_cmp++; if (strobes !== ST_RD_ACK) begin n_bad++; $display("FAIL col_cpu_ack strobes=%b exp=%b", strobes, ST_RD_ACK); end
    bus_idle();
    edges(1);
  endtask

  task automatic test_abort();
    do_reset();
    start_cycle(24'h120034, 1'b1, 1'b0, 1'b0, 1'b1);
    edges(1);
    n_cmp++; if (strobes !== ST_RD_ROW) begin n_bad++; $display("FAIL ab_row strobes=%b exp=%b", strobes, ST_RD_ROW); end
    AS = 1'b1;
    edges(1);
    n_cmp++; if (strobes !== ST_IDLE) begin n_bad++; $display("FAIL ab_release strobes=%b exp=%b", strobes, ST_IDLE); end
    // Next cycle requested during precharge must wait for IDLE.
    AS = 1'b0;
    edges(1);
    n_cmp++; if (strobes !== ST_IDLE) begin n_bad++; $display("FAIL ab_pre1 strobes=%b exp=%b", strobes, ST_IDLE); end
    edges(1);
    n_cmp++; if (strobes !== ST_IDLE) begin n_bad++; $display("FAIL ab_pre2 strobes=%b exp=%b", strobes, ST_IDLE); end
    edges(1);
    n_cmp++; if (strobes !== ST_RD_ROW) begin n_bad++; $display("FAIL ab_next_row strobes=%b exp=%b", strobes, ST_RD_ROW); end
    edges(2);
    n_cmp++; if (strobes !== ST_RD_ACK) begin n_bad++; $display("FAIL ab_next_ack strobes=%b exp=%b", strobes, ST_RD_ACK); end
    bus_idle();
    edges(1);
  endtask

  task automatic test_reset_mid_cycle();
    do_reset();
    start_cycle(24'h120034, 1'b1, 1'b0, 1'b0, 1'b1);
    edges(3);
    n_cmp++; if (strobes !== ST_RD_ACK) begin n_bad++; $display("FAIL rm_ack strobes=%b exp=%b", strobes, ST_RD_ACK); end
    RST = 1'b0;
    #1;
    n_cmp++; if (strobes !== ST_IDLE) begin n_bad++; $display("FAIL rm_async strobes=%b exp=%b", strobes, ST_IDLE); end
    n_cmp++; if (ADDR_OUT !== 11'h120) begin n_bad++; $display("FAIL rm_state_idle addr=%h exp=120", ADDR_OUT); end
    bus_idle();
    @(negedge CLK);
    RST = 1'b1;
    edges(123);
    n_cmp++; if (strobes !== ST_IDLE) begin n_bad++; $display("FAIL rm_ref_early strobes=%b exp=%b", strobes, ST_IDLE); end
    edges(1);
    n_cmp++; if (strobes !== ST_RF_CAS) begin n_bad++; $display("FAIL rm_ref_cas strobes=%b exp=%b", strobes, ST_RF_CAS); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_refresh();
    test_refresh_collision();
    test_abort();
    test_reset_mid_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
